complex_dot_product_folded_engine: RTL and testbench
====================================================

Name: complex_dot_product_folded_engine

Overview:
- Parametrised successor of the 8-element complex dot-product unit.
- Computes sum over k of a[k]*b[k], or a[k]*conj(b[k]), over a run of `total` complex elements.
- Input arrives NO_OF_UNITS elements per beat; NO_OF_MULTS physical multipliers are time-shared over each beat (FOLD = NO_OF_UNITS/NO_OF_MULTS).
- Sits between the row-streaming memory controller and the solver datapath, with valid/ready handshakes on both sides.

Parameters:
- COMP_W, 16: signed width of each real/imag component.
- NO_OF_UNITS, 8: complex elements per input beat.
- NO_OF_MULTS, 4: physical complex multipliers. Must divide NO_OF_UNITS. FOLD = NO_OF_UNITS/NO_OF_MULTS.
- ACC_W, 48: signed width of each accumulator component. Must be >= 2*COMP_W+2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- total  in  32  element count for the run; latched on accepted start.
- conj  in  1  1 = conjugate second operand; latched on accepted start.
- first_row_input  in  COMP_W*2*NO_OF_UNITS  operand a beat.
- second_row_input  in  COMP_W*2*NO_OF_UNITS  operand b beat.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- result_re  out  ACC_W  real part of dot product.
- result_im  out  ACC_W  imag part of dot product.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except IDLE.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Packing: element k (k=0 first) occupies [2*COMP_W*(NO_OF_UNITS-k)-1 -: 2*COMP_W]. Within an element, real is the upper COMP_W bits and imag the lower.
- Reset values: in_ready=0, out_valid=0, busy=0, cfg_err=0, result_re=0, result_im=0. Reset clears the FSM to IDLE, zeroes the accumulators, counters and pipeline valids, and discards any run in progress.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with total%NO_OF_UNITS != 0: pulse cfg_err, remain in IDLE.
  - start with total==0: go to DONE with result 0; out_valid high the cycle after start.
  - Otherwise: latch beats = total/NO_OF_UNITS and conj, clear the accumulators, go to RUN.
- RUN:
  - in_ready = 1 when beats_left > 0 and the slice buffer is empty or issuing its last slice this cycle.
  - An accepted beat is registered. Slice s (elements s*NO_OF_MULTS .. s*NO_OF_MULTS+NO_OF_MULTS-1) issues to the multipliers in cycle s+1 after acceptance, for s = 0..FOLD-1.
  - Sustained throughput is one beat per FOLD cycles, with no bubbles when in_valid is held high.
  - After the last beat is accepted, go to DRAIN.
- Pipeline:
  - Multiplier stage is registered. Product = (ar*br - ai*bi, ai*br + ar*bi). With conj=1: (ar*br + ai*bi, ai*br - ar*bi).
  - Full-precision products are sign-extended to ACC_W.
  - Adder-tree sum of the NO_OF_MULTS products is registered.
  - Accumulator add is registered and wraps modulo 2^ACC_W (no saturation).
- DRAIN: wait for the pipeline to empty.
  - out_valid rises exactly FOLD+3 cycles after the edge that accepted the last beat.
  - result_re/result_im hold the final accumulator value. Go to DONE.
- DONE:
  - out_valid and results are held stable until out_ready=1.
  - On that edge, out_valid falls and the FSM returns to IDLE.
  - start asserted in DONE, or in the same cycle as the handshake, is ignored.
- start outside IDLE is ignored without cfg_err.
- in_valid outside RUN is ignored; in_ready is 0 there.
- reset asserted mid-run aborts immediately; out_valid never rises for the aborted run.

Test Plan:
- NO_OF_UNITS=8, NO_OF_MULTS=4, total=8, all a=(1,2), b=(3,4), conj=0:
  - required result (-40,80);
  - out_valid exactly 5 cycles after the beat accept edge.
- Same data with conj=1 -> result (88,16).
- total=32, in_valid held high:
  - in_ready pattern 1,0 repeating, so 4 beats accepted in 8 cycles;
  - result equals the reference model sum.
- total=12 -> cfg_err single pulse, busy stays 0. Then total=0 -> out_valid next cycle with result (0,0).
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and results stable throughout, and a start during this window is ignored. Then out_ready=1 -> IDLE, busy=0.
- Assert reset asynchronously between clock edges during the 2nd beat:
  - all outputs 0 immediately;
  - no out_valid afterwards;
  - a fresh run with total=8 produces the correct result.
- Overflow check with COMP_W=16, ACC_W=34: all elements a=b=(-32768,0), many beats -> accumulator wraps modulo 2^34, matching the model.

Source files
------------

// File: rtl/complex_dot_product_folded_engine.sv
// complex_dot_product_folded_engine
//
// Folded complex dot-product engine. A run of `total` complex elements arrives
// NO_OF_UNITS elements per beat; NO_OF_MULTS complex multipliers are
// time-shared over each beat (FOLD = NO_OF_UNITS/NO_OF_MULTS slices per beat).
// The result is sum(a[k]*b[k]) or, with conj=1, sum(a[k]*conj(b[k])).
// Accumulation wraps modulo 2^ACC_W.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid & ready are both 1. On the input side the engine raises in_ready
// and the producer may present/withdraw in_valid freely. On the output side
// out_valid, result_re and result_im stay stable until the edge where
// out_ready is 1.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, total, conj    run request (IDLE only), element count, conjugate b
//   first_row_input       operand a beat, element 0 in the top bits
//   second_row_input      operand b beat, same packing
//   in_valid / in_ready   input beat handshake
//   result_re / result_im final accumulator value
//   out_valid / out_ready result handshake
//   busy                  high whenever the FSM is not IDLE
//   cfg_err               one-cycle pulse when a start is rejected
//   dbg_state             current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Parameter constraints: NO_OF_MULTS divides NO_OF_UNITS,
// ACC_W >= 2*COMP_W+2.

module complex_dot_product_folded_engine #(
  parameter int COMP_W      = 16,
  parameter int NO_OF_UNITS = 8,
  parameter int NO_OF_MULTS = 4,
  parameter int ACC_W       = 48
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [31:0]                     total,
  input  logic                            conj,
  input  logic [COMP_W*2*NO_OF_UNITS-1:0] first_row_input,
  input  logic [COMP_W*2*NO_OF_UNITS-1:0] second_row_input,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [ACC_W-1:0]                result_re,
  output logic [ACC_W-1:0]                result_im,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            cfg_err,
  output logic [1:0]                      dbg_state
);

  localparam int FOLD = NO_OF_UNITS / NO_OF_MULTS;
  localparam int EW   = 2 * COMP_W;            // one packed complex element
  localparam int BW   = EW * NO_OF_UNITS;      // one beat
  localparam int SW   = EW * NO_OF_MULTS;      // one slice
  localparam int CW   = $clog2(FOLD + 1);      // slices-left counter width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [31:0]       beats_left_q;
  logic              conj_q;
  logic              cfg_err_q;
  logic              out_valid_q;
  logic [ACC_W-1:0]  acc_re_q, acc_im_q;
  logic [ACC_W-1:0]  res_re_q, res_im_q;

  // Slice buffer: the accepted beat is shifted up by one slice per cycle so
  // the slice being issued always sits in the top SW bits.
  logic [BW-1:0]     a_buf_q, b_buf_q;
  logic [CW-1:0]     slices_left_q;

  logic                    mult_vld_q;
  logic signed [ACC_W-1:0] mre_d [NO_OF_MULTS];
  logic signed [ACC_W-1:0] mim_d [NO_OF_MULTS];
  logic signed [ACC_W-1:0] mre_q [NO_OF_MULTS];
  logic signed [ACC_W-1:0] mim_q [NO_OF_MULTS];

  logic              sum_vld_q;
  logic [ACC_W-1:0]  sum_re_d, sum_im_d;
  logic [ACC_W-1:0]  sum_re_q, sum_im_q;

  logic issuing, last_issue, accept;

  assign issuing    = (slices_left_q != '0);
  assign last_issue = (slices_left_q == CW'(1));
  // A new beat can land in the buffer on the same edge the last slice leaves.
  assign in_ready   = (state_q == S_RUN) && (beats_left_q != 32'd0) &&
                      (!issuing || last_issue);
  assign accept     = in_valid && in_ready;

  assign result_re  = res_re_q;
  assign result_im  = res_im_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign cfg_err    = cfg_err_q;
  assign dbg_state  = state_q;

  // Complex multipliers fed from the top slice of the buffer.
  for (genvar m = 0; m < NO_OF_MULTS; m++) begin : g_mult
    logic signed [COMP_W-1:0] ar, ai, br, bi;
    logic signed [EW-1:0]     p_rr, p_ii, p_ir, p_ri;

    assign ar = a_buf_q[BW-1-m*EW -: COMP_W];
    assign ai = a_buf_q[BW-1-m*EW-COMP_W -: COMP_W];
    assign br = b_buf_q[BW-1-m*EW -: COMP_W];
    assign bi = b_buf_q[BW-1-m*EW-COMP_W -: COMP_W];

    assign p_rr = EW'(ar) * EW'(br);
    assign p_ii = EW'(ai) * EW'(bi);
    assign p_ir = EW'(ai) * EW'(br);
    assign p_ri = EW'(ar) * EW'(bi);

    // Sign-extend before combining so the sum keeps full precision.
    assign mre_d[m] = conj_q ? (ACC_W'(p_rr) + ACC_W'(p_ii))
                             : (ACC_W'(p_rr) - ACC_W'(p_ii));
    assign mim_d[m] = conj_q ? (ACC_W'(p_ir) - ACC_W'(p_ri))
                             : (ACC_W'(p_ir) + ACC_W'(p_ri));
  end

  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    for (int m = 0; m < NO_OF_MULTS; m++) begin
      sum_re_d = sum_re_d + mre_q[m];
      sum_im_d = sum_im_d + mim_q[m];
    end
  end

  // Datapath pipeline: slice buffer -> multipliers -> adder tree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_buf_q       <= '0;
      b_buf_q       <= '0;
      slices_left_q <= '0;
      mult_vld_q    <= 1'b0;
      mre_q         <= '{default: '0};
      mim_q         <= '{default: '0};
      sum_vld_q     <= 1'b0;
      sum_re_q      <= '0;
      sum_im_q      <= '0;
    end else begin
      if (accept) begin
        a_buf_q       <= first_row_input;
        b_buf_q       <= second_row_input;
        slices_left_q <= CW'(FOLD);
      end else if (issuing) begin
        a_buf_q       <= a_buf_q << SW;
        b_buf_q       <= b_buf_q << SW;
        slices_left_q <= slices_left_q - CW'(1);
      end

      mult_vld_q <= issuing;
      if (issuing) begin
        mre_q <= mre_d;
        mim_q <= mim_d;
      end

      sum_vld_q <= mult_vld_q;
      if (mult_vld_q) begin
        sum_re_q <= sum_re_d;
        sum_im_q <= sum_im_d;
      end
    end
  end

  // Control FSM with accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beats_left_q <= '0;
      conj_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      res_re_q     <= '0;
      res_im_q     <= '0;
    end else begin
      cfg_err_q <= 1'b0;

      if (sum_vld_q) begin
        acc_re_q <= acc_re_q + sum_re_q;
        acc_im_q <= acc_im_q + sum_im_q;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if ((total % 32'(NO_OF_UNITS)) != 32'd0) begin
              cfg_err_q <= 1'b1;
            end else if (total == 32'd0) begin
              res_re_q    <= '0;
              res_im_q    <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              beats_left_q <= total / 32'(NO_OF_UNITS);
              conj_q       <= conj;
              acc_re_q     <= '0;
              acc_im_q     <= '0;
              state_q      <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (accept) begin
            beats_left_q <= beats_left_q - 32'd1;
            if (beats_left_q == 32'd1) state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // With every stage empty the accumulator holds the final sum.
          if (!issuing && !mult_vld_q && !sum_vld_q) begin
            res_re_q    <= acc_re_q;
            res_im_q    <= acc_im_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_dot_product_folded_engine.sv
// Testbench for complex_dot_product_folded_engine (COMP_W=16, 8 units,
// 4 multipliers, ACC_W=34 so that accumulator wrap-around is reachable).

module tb_complex_dot_product_folded_engine;

  localparam int COMP_W = 16;
  localparam int NU     = 8;
  localparam int NM     = 4;
  localparam int ACC_W  = 34;
  localparam int EW     = 2 * COMP_W;
  localparam int BW     = EW * NU;
  localparam int LAT    = NU / NM + 3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      total;
  logic             conj;
  logic [BW-1:0]    first_row_input;
  logic [BW-1:0]    second_row_input;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] result_re;
  logic [ACC_W-1:0] result_im;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             cfg_err;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  complex_dot_product_folded_engine #(
    .COMP_W(COMP_W), .NO_OF_UNITS(NU), .NO_OF_MULTS(NM), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .conj(conj),
    .first_row_input(first_row_input), .second_row_input(second_row_input),
    .in_valid(in_valid), .in_ready(in_ready),
    .result_re(result_re), .result_im(result_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*ACC_W-1:0] exp_q[$];
  longint exp_re, exp_im;   // reference sum in plain integer arithmetic
  bit     cur_conj;
  logic [7:0] rdy_trace;
  int     run_cycles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] tot, input bit cj);
    start    = 1'b1;
    total    = tot;
    conj     = cj;
    cur_conj = cj;
    exp_re   = 0;
    exp_im   = 0;
    tick();
    start    = 1'b0;
  endtask

  // Puts one beat on the inputs and folds its elements into the reference sum.
  task automatic load_beat(input bit fixed, input logic [15:0] far, input logic [15:0] fai,
                           input logic [15:0] fbr, input logic [15:0] fbi);
    logic [BW-1:0] a, b;
    a = '0;
    b = '0;
    for (int k = 0; k < NU; k++) begin
      logic signed [15:0] ar, ai, br, bi;
      if (fixed) begin
        ar = far; ai = fai; br = fbr; bi = fbi;
      end else begin
        ar = 16'($urandom_range(0, 65535));
        ai = 16'($urandom_range(0, 65535));
        br = 16'($urandom_range(0, 65535));
        bi = 16'($urandom_range(0, 65535));
      end
      a[EW*(NU-k)-1 -: EW] = {ar, ai};
      b[EW*(NU-k)-1 -: EW] = {br, bi};
      if (!cur_conj) begin
        exp_re += longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
        exp_im += longint'(ai) * longint'(br) + longint'(ar) * longint'(bi);
      end else begin
        exp_re += longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
        exp_im += longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
      end
    end
    first_row_input  = a;
    second_row_input = b;
  endtask

  task automatic push_expected();
    logic [ACC_W-1:0] er, ei;
    er = exp_re[ACC_W-1:0];
    ei = exp_im[ACC_W-1:0];
    exp_q.push_back({er, ei});
  endtask

  // Streams nbeats beats with in_valid held high; returns just after the
  // edge that accepted the last beat.
  task automatic drive_run(input int nbeats, input bit fixed, input logic [15:0] far,
                           input logic [15:0] fai, input logic [15:0] fbr, input logic [15:0] fbi);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    rdy_trace = '0;
    load_beat(fixed, far, fai, fbr, fbi);
    in_valid = 1'b1;
    while (sent < nbeats && cyc < 1000) begin
      if (cyc < 8) rdy_trace[7-cyc] = in_ready;
      if (in_ready) begin
        sent++;
        tick();
        if (sent < nbeats) load_beat(fixed, far, fai, fbr, fbi);
      end else begin
        tick();
      end
      cyc++;
    end
    in_valid   = 1'b0;
    run_cycles = cyc;
    check("beats_accepted", 64'(sent), 64'(nbeats));
    push_expected();
  endtask

  // Waits for out_valid, checks its latency and the result against the queue.
  task automatic wait_result(input int exp_lat);
    int lat;
    logic [2*ACC_W-1:0] e;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("out_valid_latency", 64'(lat), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed result with no expectation");
    end else begin
      e = exp_q.pop_front();
      check("result_re", 64'(result_re), 64'(e[2*ACC_W-1:ACC_W]));
      check("result_im", 64'(result_im), 64'(e[ACC_W-1:0]));
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ack_out_valid_low", 64'(out_valid), 64'd0);
    check("ack_busy_low", 64'(busy), 64'd0);
  endtask

  // ---------------- directed / random sequence ----------------
  initial begin
    logic [ACC_W-1:0] held_re, held_im;
    int               seen_valid;

    reset = 1'b1; start = 1'b0; total = '0; conj = 1'b0;
    first_row_input = '0; second_row_input = '0;
    in_valid = 1'b0; out_ready = 1'b0; cur_conj = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cfg_err", 64'(cfg_err), 64'd0);
    check("reset_result_re", 64'(result_re), 64'd0);
    check("reset_result_im", 64'(result_im), 64'd0);
    reset = 1'b0;
    tick();

    // Fixed data (1+2i)*(3+4i) over 8 elements.
    start_run(32'd8, 1'b0);
    check("run_busy", 64'(busy), 64'd1);
    drive_run(1, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4);
    check("ref_re_plain", 64'(exp_re), 64'(-40));
    wait_result(LAT);
    ack();

    // Same data with conjugation.
    start_run(32'd8, 1'b1);
    drive_run(1, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4);
    check("ref_re_conj", 64'(exp_re), 64'd88);
    wait_result(LAT);
    ack();

    // Four back-to-back beats: in_ready alternates 1,0.
    start_run(32'd32, 1'b0);
    drive_run(4, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    check("in_ready_pattern", 64'(rdy_trace), 64'(8'b1010_1010));
    check("four_beat_cycles", 64'(run_cycles), 64'd7);
    wait_result(LAT);
    ack();

    // Rejected start, then a zero-length run.
    start_run(32'd12, 1'b0);
    check("cfg_err_pulse", 64'(cfg_err), 64'd1);
    check("cfg_err_busy", 64'(busy), 64'd0);
    tick();
    check("cfg_err_clear", 64'(cfg_err), 64'd0);
    check("cfg_err_busy2", 64'(busy), 64'd0);
    start_run(32'd0, 1'b0);
    push_expected();
    wait_result(0);
    ack();

    // DONE hold with out_ready low; a start inside the window is ignored.
    start_run(32'd16, 1'b1);
    drive_run(2, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    wait_result(LAT);
    held_re = result_re;
    held_im = result_im;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      total = 32'd8;
      tick();
      check("done_hold_valid", 64'(out_valid), 64'd1);
      check("done_hold_re", 64'(result_re), 64'(held_re));
      check("done_hold_im", 64'(result_im), 64'(held_im));
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("handshake_valid_low", 64'(out_valid), 64'd0);
    check("handshake_busy_low", 64'(busy), 64'd0);
    tick();
    check("start_at_handshake_ignored", 64'(busy), 64'd0);

    // Asynchronous reset while the second beat is in flight.
    start_run(32'd32, 1'b0);
    load_beat(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    in_valid = 1'b1;
    tick();
    load_beat(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    check("abort_ready_for_beat2", 64'(in_ready), 64'd1);
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result_re", 64'(result_re), 64'd0);
    check("abort_result_im", 64'(result_im), 64'd0);
    check("abort_cfg_err", 64'(cfg_err), 64'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    check("abort_no_out_valid", 64'(seen_valid), 64'd0);
    start_run(32'd8, 1'b0);
    drive_run(1, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    wait_result(LAT);
    ack();

    // Randomised runs with random consumer delay.
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = $urandom_range(1, 6);
      start_run(32'(nb * NU), 1'($urandom_range(0, 1)));
      drive_run(nb, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
      wait_result(LAT);
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      ack();
    end

    // Accumulator wrap: 40 products of 2^30 wrap modulo 2^34.
    start_run(32'd40, 1'b0);
    drive_run(5, 1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
    check("wrap_ref_re", 64'(exp_re[ACC_W-1:0]), 64'h2_0000_0000);
    wait_result(LAT);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
